shift_issue_seq: RTL
====================

Name: shift_issue_seq

Overview:
Sequencing stage directly upstream of the combinational bidirectional shifter in the Mosaic functional unit. Accepts shift/rotate requests over a valid/ready handshake and registers the operands. Drives the shifter's data, amount, direction and logical/arithmetic inputs, then captures the shifter's result. Rotates are built from two shifter passes ORed together, so the block owns a small FSM plus result buffering with output backpressure.

Parameters:
TAG_W, 4, width of the opaque request tag carried from request to result.

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST_N  in  1  reset, asynchronous, active-low
FLUSH  in  1  synchronous abort; discards any in-flight or held op
IN_VALID  in  1  request valid
IN_READY  out  1  request accepted when IN_VALID & IN_READY at a rising edge
IN_OP  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
IN_A  in  32  data operand
IN_B  in  5  shift amount
IN_TAG  in  TAG_W  request tag
SH_X  out  32  to shifter data input
SH_S  out  5  to shifter amount
SH_LEFT  out  1  to shifter direction (1 = left)
SH_LOG  out  1  to shifter logical select (1 = logical right)
SH_Z  in  32  shifter result (combinational from SH_*)
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer ready
OUT_DATA  out  32  result
OUT_TAG  out  TAG_W  tag of the result
OUT_ERR  out  1  illegal opcode flag, qualified by OUT_VALID

Behaviour:
- Reset (RST_N low, async): state IDLE; OUT_VALID, OUT_DATA, OUT_TAG, OUT_ERR, op/amount/partial registers all 0. IN_READY is 1 once in IDLE.
- States: IDLE, PASS1, PASS2, DONE.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY). It is combinational from state and OUT_READY only, never from IN_VALID.
- Accept: latch op, A, B, tag, then go to PASS1. An illegal op goes straight to DONE with OUT_DATA=0 and OUT_ERR=1.
- PASS1 shifter drive:
  - SH_X=A, SH_S=B.
  - SLL and ROL: LEFT=1.
  - SRL and ROR: LEFT=0, LOG=1.
  - SRA: LEFT=0, LOG=0.
- End of PASS1:
  - Non-rotate: OUT_DATA <= SH_Z, go to DONE.
  - Rotate with B==0: OUT_DATA <= A, go to DONE.
  - Rotate with B!=0: partial <= SH_Z, go to PASS2.
- PASS2 shifter drive:
  - SH_X=A, SH_S=(32-B)&31 (5-bit two's complement of B).
  - Direction is opposite to PASS1; the right-shift pass is always logical.
  - End of PASS2: OUT_DATA <= partial | SH_Z, go to DONE.
- DONE: OUT_VALID=1; OUT_DATA, OUT_TAG and OUT_ERR are held stable while OUT_READY=0.
  - On OUT_READY: if a new request is accepted the same edge, go to PASS1 (or DONE if illegal); otherwise go to IDLE.
- Latency from accept edge to OUT_VALID: 2 cycles for SLL/SRL/SRA and for rotate by 0; 3 cycles for rotate by nonzero. Peak throughput is 1 op per 2 cycles.
- SH_* in IDLE/DONE: SH_X=0, SH_S=0, SH_LEFT=0, SH_LOG=1. This is a quiet encoding so no toggling.
- FLUSH has priority over every transition: go to IDLE, OUT_VALID=0, and no accept that cycle (IN_READY forced 0 while FLUSH=1).
- Reset mid-operation: immediate return to reset values; no partial result ever emitted.
- OUT_VALID deasserts only after a handshake, or on FLUSH or reset.

Decomposition:
- Shared package (fu_pkg):
  - opcode constants OP_SLL..OP_ROR.
  - state encoding (2-bit enum).
  - quiet SH_* drive constants.
- One natural sub-module, shift_op_decode: purely combinational. Maps (op, pass, B) to (SH_S, SH_LEFT, SH_LOG, is_rotate, illegal).
- FSM, registers and handshake stay in shift_issue_seq.
- The shifter itself is instantiated beside this block at the functional-unit level, not inside it.

Test Plan:
- SLL A=0x00000001 B=31, OUT_READY=1 -> OUT_DATA=0x80000000, OUT_VALID exactly 2 cycles after accept, OUT_ERR=0.
- SRA A=0x80000000 B=4 -> 0xF8000000; SRL same operands -> 0x08000000.
- ROL A=0x80000001 B=1 -> 0x00000003 after 3 cycles. ROR A=0x00000001 B=0 -> 0x00000001 after 2 cycles. ROR A=0x12345678 B=8 -> 0x78123456.
- Backpressure: hold OUT_READY=0 for 5 cycles with a completed op -> OUT_VALID=1 and OUT_DATA/OUT_TAG stable, IN_READY=0. Raise OUT_READY with a new IN_VALID -> both handshakes occur on the same edge.
- IN_OP=3'b111, A=0xFFFFFFFF, tag=0xA -> OUT_ERR=1, OUT_DATA=0, OUT_TAG=0xA, 1 cycle after accept.
- FLUSH during PASS2 of a ROL, and RST_N low during PASS1 -> no OUT_VALID for that op, next cycle IN_READY=1, all outputs at reset values after reset.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared definitions for the Mosaic shift sequencing stage: opcodes, FSM
// state encoding and the idle drive pattern for the external shifter.
package fu_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shifter inputs parked here whenever no pass is running, so they never toggle.
  localparam logic [31:0] SH_X_QUIET    = 32'd0;
  localparam logic [4:0]  SH_S_QUIET    = 5'd0;
  localparam logic        SH_LEFT_QUIET = 1'b0;
  localparam logic        SH_LOG_QUIET  = 1'b1;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_ROR);
  endfunction

endpackage

// File: rtl/shift_op_decode.sv
// Combinational mapping of (opcode, pass, amount) onto the shifter controls.
// A rotate's second pass runs the opposite direction by (32-B) mod 32, always logical.
module shift_op_decode
  import fu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       pass2,
  input  logic [4:0] b,
  output logic [4:0] sh_s,
  output logic       sh_left,
  output logic       sh_log,
  output logic       is_rotate,
  output logic       illegal
);

  always_comb begin
    is_rotate = (op == OP_ROL) || (op == OP_ROR);
    illegal   = op_illegal(op);
    if (pass2) begin
      sh_s    = 5'd0 - b;
      sh_left = (op == OP_ROR);
      sh_log  = 1'b1;
    end else begin
      sh_s    = b;
      sh_left = (op == OP_SLL) || (op == OP_ROL);
      sh_log  = (op != OP_SRA);
    end
  end

endmodule

// File: rtl/shift_issue_seq.sv
// Issue/sequencing stage in front of the combinational shifter: one pass for
// plain shifts, two ORed passes for rotates, result held until consumed.
module shift_issue_seq
  import fu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [4:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sh_x,
  output logic [4:0]       sh_s,
  output logic             sh_left,
  output logic             sh_log,
  input  logic [31:0]      sh_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic [31:0]        a_reg, a_next;
  logic [4:0]         b_reg, b_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic [31:0]        partial_reg, partial_next;
  logic [31:0]        out_data_reg, out_data_next;
  logic [TAG_W-1:0]   out_tag_reg, out_tag_next;
  logic               out_err_reg, out_err_next;

  logic               in_pass;
  logic [2:0]         dec_op;
  logic [4:0]         dec_s;
  logic               dec_left, dec_log, dec_rotate, dec_illegal;
  logic               accept;

  assign in_pass = (state_reg == ST_PASS1) || (state_reg == ST_PASS2);
  // Outside a pass the decoder looks at the incoming opcode to flag illegal ops on accept.
  assign dec_op  = in_pass ? op_reg : in_op;

  shift_op_decode u_decode (
    .op        (dec_op),
    .pass2     (state_reg == ST_PASS2),
    .b         (b_reg),
    .sh_s      (dec_s),
    .sh_left   (dec_left),
    .sh_log    (dec_log),
    .is_rotate (dec_rotate),
    .illegal   (dec_illegal)
  );

  assign in_ready  = !flush && ((state_reg == ST_IDLE) ||
                                ((state_reg == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = out_data_reg;
  assign out_tag   = out_tag_reg;
  assign out_err   = out_err_reg;

  always_comb begin
    sh_x    = SH_X_QUIET;
    sh_s    = SH_S_QUIET;
    sh_left = SH_LEFT_QUIET;
    sh_log  = SH_LOG_QUIET;
    if (in_pass) begin
      sh_x    = a_reg;
      sh_s    = dec_s;
      sh_left = dec_left;
      sh_log  = dec_log;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    tag_next      = tag_reg;
    partial_next  = partial_reg;
    out_data_next = out_data_reg;
    out_tag_next  = out_tag_reg;
    out_err_next  = out_err_reg;

    case (state_reg)
      ST_PASS1: begin
        out_tag_next = tag_reg;
        out_err_next = 1'b0;
        if (!dec_rotate) begin
          out_data_next = sh_z;
          state_next    = ST_DONE;
        end else if (b_reg == 5'd0) begin
          out_data_next = a_reg;
          state_next    = ST_DONE;
        end else begin
          partial_next = sh_z;
          state_next   = ST_PASS2;
        end
      end
      ST_PASS2: begin
        out_data_next = partial_reg | sh_z;
        state_next    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: ;
    endcase

    // A new request may land in IDLE or on the same edge the held result drains.
    if (accept) begin
      op_next  = in_op;
      a_next   = in_a;
      b_next   = in_b;
      tag_next = in_tag;
      if (dec_illegal) begin
        out_data_next = 32'd0;
        out_tag_next  = in_tag;
        out_err_next  = 1'b1;
        state_next    = ST_DONE;
      end else begin
        state_next = ST_PASS1;
      end
    end

    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= 3'd0;
      a_reg        <= 32'd0;
      b_reg        <= 5'd0;
      tag_reg      <= '0;
      partial_reg  <= 32'd0;
      out_data_reg <= 32'd0;
      out_tag_reg  <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      tag_reg      <= tag_next;
      partial_reg  <= partial_next;
      out_data_reg <= out_data_next;
      out_tag_reg  <= out_tag_next;
      out_err_reg  <= out_err_next;
    end
  end

endmodule
